// File: rtl/bram2rgb_out.sv
// Scans a 4x-upscaled frame buffer out of BRAM as free-running RGB video with sync and data enable.
// Latency: two pclk from counter position to pixel; no backpressure, timing never stalls.
module bram2rgb_out #(
  parameter int ACTIVE_COLS = 320,
  parameter int ACTIVE_ROWS = 180,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        frame_ready,
  input  logic [23:0] bram_dout,
  output logic [15:0] bram_addr,
  output logic        bram_en,
  output logic        o_HSync,
  output logic        o_VSync,
  output logic        vde,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        start_frame
);

  localparam int H_ACTIVE = 4 * ACTIVE_COLS;
  localparam int V_ACTIVE = 4 * ACTIVE_ROWS;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0]   COLS   = 16'(ACTIVE_COLS);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [15:0]   line_base;
  logic          frame_ok;
  logic          h_wrap, v_wrap;
  logic          hsync_raw, vsync_raw, active_raw, first_raw;
  logic [15:0]   pix_col;
  logic [1:0]    hs_d, vs_d, act_d, first_d;

  always_comb begin
    h_wrap     = (h_cnt == H_LAST);
    v_wrap     = (v_cnt == V_LAST);
    hsync_raw  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vsync_raw  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    active_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    first_raw  = (h_cnt == '0) && (v_cnt == '0);
    pix_col    = 16'(h_cnt >> 2);
  end

  // Raster counters and the per-source-row base address (advances after every 4th line).
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      line_base <= '0;
      frame_ok  <= 1'b0;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        if (v_wrap) begin
          v_cnt     <= '0;
          line_base <= '0;
        end else begin
          v_cnt <= v_cnt + VW'(1);
          if (v_cnt[1:0] == 2'd3 && v_cnt < V_ACT)
            line_base <= line_base + COLS;
        end
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (h_wrap && v_wrap)
        frame_ok <= frame_ready;
    end
  end

  // Read issue; the address holds outside the active area.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      bram_en   <= 1'b0;
      bram_addr <= '0;
    end else begin
      bram_en <= active_raw;
      if (active_raw)
        bram_addr <= line_base + pix_col;
    end
  end

  // Timing delayed two stages so sync/vde line up with the returned pixel.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hs_d    <= '0;
      vs_d    <= '0;
      act_d   <= '0;
      first_d <= '0;
      rgb_r   <= '0;
      rgb_g   <= '0;
      rgb_b   <= '0;
    end else begin
      hs_d    <= {hs_d[0], hsync_raw};
      vs_d    <= {vs_d[0], vsync_raw};
      act_d   <= {act_d[0], active_raw};
      first_d <= {first_d[0], first_raw};
      if (act_d[0] && frame_ok)
        {rgb_r, rgb_g, rgb_b} <= bram_dout;
      else
        {rgb_r, rgb_g, rgb_b} <= '0;
    end
  end

  assign o_HSync     = hs_d[1];
  assign o_VSync     = vs_d[1];
  assign vde         = act_d[1];
  assign start_frame = first_d[1];

endmodule

// File: tb/tb_bram2rgb_out.sv
// Drives a small raster through bram2rgb_out and checks every output against a position-based model.
module tb_bram2rgb_out;

  localparam int COLS = 8, ROWS = 4;
  localparam int HFP = 3, HSY = 2, HBP = 4, VFP = 2, VSY = 2, VBP = 3;
  localparam int HA = 4 * COLS, VA = 4 * ROWS;
  localparam int HT = HA + HFP + HSY + HBP, VT = VA + VFP + VSY + VBP, FT = HT * VT;
  localparam int NPIX = COLS * ROWS;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_ready = 1'b1;
  logic [23:0] bram_dout;
  logic [15:0] bram_addr;
  logic        bram_en, o_HSync, o_VSync, vde, start_frame;
  logic [7:0]  rgb_r, rgb_g, rgb_b;

  logic [23:0] mem [0:NPIX-1];
  assign bram_dout = mem[bram_addr[4:0]];

  bram2rgb_out #(
    .ACTIVE_COLS(COLS), .ACTIVE_ROWS(ROWS),
    .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .pclk(pclk), .rst(rst), .frame_ready(frame_ready), .bram_dout(bram_dout),
    .bram_addr(bram_addr), .bram_en(bram_en), .o_HSync(o_HSync), .o_VSync(o_VSync),
    .vde(vde), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .start_frame(start_frame)
  );

  always #4 pclk = ~pclk;

  int          total = 0;
  int          bad = 0;
  int          n = 0;
  int          en_cnt = 0;
  logic [15:0] last_addr = '0;
  bit          fok [0:15];

  function automatic int hh(input int q); return q % HT; endfunction
  function automatic int vv(input int q); return (q / HT) % VT; endfunction
  function automatic bit act(input int q); return hh(q) < HA && vv(q) < VA; endfunction
  function automatic bit hs(input int q); return hh(q) >= HA + HFP && hh(q) < HA + HFP + HSY; endfunction
  function automatic bit vs(input int q); return vv(q) >= VA + VFP && vv(q) < VA + VFP + VSY; endfunction
  function automatic int addr(input int q); return (vv(q) / 4) * COLS + hh(q) / 4; endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // Outputs after edge n show position n-2; the read request shows position n-1.
  task automatic check_outputs();
    logic [3:0]  e_ctl;
    logic [23:0] e_rgb;
    logic        e_en;
    e_ctl = '0;
    e_rgb = '0;
    e_en  = 1'b0;
    if (n >= 2) begin
      e_ctl = {hs(n-2), vs(n-2), act(n-2), ((n-2) % FT) == 0};
      if (act(n-2) && fok[(n-2) / FT])
        e_rgb = mem[addr(n-2)];
    end
    if (n >= 1 && act(n-1)) begin
      e_en      = 1'b1;
      last_addr = 16'(addr(n-1));
    end
    check("ctl_hs_vs_vde_sf", {o_HSync, o_VSync, vde, start_frame}, e_ctl);
    check("bram_en", bram_en, e_en);
    check("bram_addr", bram_addr, last_addr);
    check("rgb", {rgb_r, rgb_g, rgb_b}, e_rgb);
    check("addr_bound", bram_en && bram_addr > 16'(NPIX - 1), 1'b0);
    if (bram_en) en_cnt++;
    if (n >= 1 && (n - 1) % FT == FT - 1) begin
      check("en_per_frame", en_cnt, HA * VA);
      en_cnt = 0;
    end
  endtask

  task automatic restart_model();
    n = 0;
    en_cnt = 0;
    last_addr = '0;
    for (int i = 0; i < 16; i++) fok[i] = 1'b0;
  endtask

  // Record what the DUT will latch at the next edge when it sits on the last position of a frame.
  task automatic note_latch();
    if (n % FT == FT - 1) fok[n / FT + 1] = frame_ready;
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    n++;
    check_outputs();
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 24'(i);
    restart_model();
    repeat (3) @(posedge pclk);
    #1;
    rst = 1'b0;
    check_outputs();
    note_latch();

    // Frames 0..2 with frame_ready high; drop it halfway through frame 2.
    while (n < 3 * FT) begin
      step();
      if (n == 2 * FT + FT / 2) frame_ready = 1'b0;
      note_latch();
    end

    for (int i = 0; i < NPIX; i++) mem[i] = 24'($urandom());

    // Frames 3..4 with frame_ready toggling randomly every cycle.
    while (n < 5 * FT) begin
      step();
      frame_ready = 1'($urandom_range(0, 1));
      note_latch();
    end

    frame_ready = 1'b1;
    while (n < 5 * FT + 3 * HT + 10) begin
      step();
      note_latch();
    end

    // Sub-period reset pulse mid-line.
    rst = 1'b1;
    #1;
    check("rst_async_clear",
          {bram_addr, bram_en, o_HSync, o_VSync, vde, rgb_r, rgb_g, rgb_b, start_frame}, '0);
    #1;
    rst = 1'b0;
    restart_model();
    check_outputs();
    note_latch();

    while (n < 2 * FT + 5) begin
      step();
      note_latch();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
